// File: rtl/cpu_bus_unit_if.sv
// Memory-side bus of cpu_bus_unit: request/ack handshake with address,
// write data and read data. The master drives the request; the slave answers.
interface cpu_bus_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/cpu_bus_unit.sv
// Variable-latency bus unit between the control unit's bus_op stream and memory:
// req/ack handshake with wait states, optional watchdog, stall output and metrics.
module cpu_bus_unit #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DATA_W   = 8,
  parameter int                 CNT_W    = 48,
  parameter int                 MAX_WAIT = 255,
  parameter logic [DATA_W-1:0]  OPEN_BUS = DATA_W'(8'hFF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        bus_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] cb_opcode,
  output logic [DATA_W-1:0] rdata,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  cpu_bus_unit_if.master    mem
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_IF    = 3'd1,
    OP_READ  = 3'd2,
    OP_WRITE = 3'd3,
    OP_IF_CB = 3'd4
  } bus_op_e;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam int                WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  // Encodings 5-7 are reserved and behave exactly like NONE.
  function automatic bus_op_e decode_op(input logic [2:0] raw);
    case (raw)
      3'd1:    return OP_IF;
      3'd2:    return OP_READ;
      3'd3:    return OP_WRITE;
      3'd4:    return OP_IF_CB;
      default: return OP_NONE;
    endcase
  endfunction

  state_e            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  bus_op_e           lat_op;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  bus_op_e           new_op;
  bus_op_e           cur_op;
  logic              capture;
  logic              complete;
  logic              abort;
  logic              watchdog_hit;
  logic [DATA_W-1:0] load_data;

  assign new_op       = decode_op(bus_op);
  assign watchdog_hit = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);
  assign load_data    = complete ? mem.rdata : OPEN_BUS;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_next = state;
    mem.req    = 1'b0;
    mem.we     = 1'b0;
    mem.addr   = addr;
    mem.wdata  = wdata;
    stall      = 1'b0;
    cur_op     = new_op;
    capture    = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;

    case (state)
      S_IDLE: begin
        if (new_op != OP_NONE) begin
          mem.req = 1'b1;
          mem.we  = (new_op == OP_WRITE);
          if (mem.ack) begin
            complete = 1'b1;
          end else begin
            stall      = 1'b1;
            capture    = 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Address/data come from the latched copies so they stay stable
        // no matter what the control unit presents while frozen.
        cur_op    = lat_op;
        mem.req   = 1'b1;
        mem.we    = (lat_op == OP_WRITE);
        mem.addr  = lat_addr;
        mem.wdata = lat_wdata;
        if (mem.ack) begin
          complete   = 1'b1;
          state_next = S_IDLE;
        end else if (watchdog_hit) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (rst) begin
      mem.req = 1'b0;
      mem.we  = 1'b0;
      stall   = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      opcode    <= '0;
      cb_opcode <= '0;
      rdata     <= '0;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_next;
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      stall_cnt <= stall_cnt + CNT_W'(stall);

      if (capture) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      if (complete || abort) begin
        case (cur_op)
          OP_IF:    opcode    <= load_data;
          OP_IF_CB: cb_opcode <= load_data;
          OP_READ:  rdata     <= load_data;
          default:  ;
        endcase
      end

      if (abort) begin
        timeout <= 1'b1;
      end
    end
  end

  // NOTE: the transfer copy is pure datapath and is only read in WAIT, which
  // is always entered through a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      lat_op    <= new_op;
      lat_addr  <= addr;
      lat_wdata <= wdata;
    end
  end

endmodule
